alu_issue_ctrl: RTL and testbench

- Upstream side of the ALU instruction interface: generates the Instruction_struct word the ALU consumes and collects the ALU result.
- Accepts instruction words from a producer over a valid/ready handshake and buffers them in an in-order FIFO.
- Presents the FIFO head to the combinational ALU and registers the returned alu_out into a result stream with valid/ready, a sequence tag and an error flag.
- Sits between the instruction source (testbench or decode stage) and the alu block.

---
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: upstream side of the ALU instruction interface.
// Instructions are buffered in an in-order FIFO. The head is presented
// combinationally to the ALU, and the returned result is captured into a
// registered result stream with a sequence tag and an error flag.
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [67:0]              in_iw,
    output logic [67:0]              alu_iw,
    input  logic [31:0]              alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] OPC_DIV = 3'd3;
    localparam logic [2:0] OPC_SR  = 3'd5;

    // An instruction is rejected when its opcode is outside ADD..SR
    // or when it divides by zero.
    function automatic logic issue_error(input logic [2:0] opc, input logic [31:0] b);
        logic illegal;
        logic div_zero;
        illegal  = (opc > OPC_SR);
        div_zero = (opc == OPC_DIV) && (b == 32'd0);
        return illegal || div_zero;
    endfunction

    logic [67:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             res_err_q, res_err_d;
    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;

    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             issue_s;
    logic [67:0]      head_s;
    logic             err_s;

    assign empty_s = (occ_q == {OCC_W{1'b0}});
    assign full_s  = (occ_q == OCC_W'(DEPTH));
    assign push_s  = in_valid && !full_s;
    assign issue_s = !empty_s && (!res_valid_q || res_ready);
    assign head_s  = empty_s ? 68'd0 : mem_q[rd_ptr_q];
    assign err_s   = issue_error(head_s[67:65], head_s[31:0]);

    assign in_ready  = !full_s;
    assign alu_iw    = head_s;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign res_err   = res_err_q;
    assign occupancy = occ_q;

    // Next-state logic for the FIFO pointers, occupancy and result register.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        tag_cnt_d   = tag_cnt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, issue_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (issue_s) begin
            // The ALU result is discarded for rejected instructions.
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            res_valid_d = 1'b1;
            res_tag_d   = tag_cnt_q;
            tag_cnt_d   = tag_cnt_q + TAG_W'(1);
            res_err_d   = err_s;
            res_data_d  = err_s ? 32'd0 : alu_out;
        end else if (res_valid_q && res_ready && empty_s) begin
            // Data, tag and error keep their last values after the drain.
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // Control and result state, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            occ_q       <= {OCC_W{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
            res_tag_q   <= {TAG_W{1'b0}};
            res_err_q   <= 1'b0;
            tag_cnt_q   <= {TAG_W{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
            tag_cnt_q   <= tag_cnt_d;
        end
    end

    // FIFO storage. Stale entries are harmless because the head reads as
    // zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_iw;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a
// queue-based reference model of the expected result stream.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [67:0] in_iw;
    logic [67:0] alu_iw;
    logic [31:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic        res_err;
    logic [2:0]  occupancy;

    int total;
    int bad;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic        e;
    } exp_t;

    typedef struct {
        logic        acc;
        logic        rv;
        logic        rdy;
        logic [31:0] d;
        logic [3:0]  t;
        logic        e;
        logic [2:0]  occ;
        logic [67:0] aiw;
    } obs_t;

    exp_t exp_q[$];
    int   next_tag;

    alu_issue_ctrl #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_iw(in_iw),
        .alu_iw(alu_iw), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_err(res_err),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; returns junk for cases the controller must ignore.
    always_comb begin
        logic [31:0] a;
        logic [31:0] b;
        a = alu_iw[63:32];
        b = alu_iw[31:0];
        case (alu_iw[67:65])
            3'd0:    alu_out = a + b;
            3'd1:    alu_out = a - b;
            3'd2:    alu_out = a * b;
            3'd3:    alu_out = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd4:    alu_out = a << b[4:0];
            3'd5:    alu_out = a >> b[4:0];
            default: alu_out = a ^ b ^ 32'h5A5A_5A5A;
        endcase
    end

    function automatic logic [67:0] mk(input int opc, input logic [31:0] a, input logic [31:0] b);
        logic [2:0] o;
        o = 3'(opc);
        return {o, 1'b0, a, b};
    endfunction

    function automatic logic [67:0] rand_iw();
        logic [2:0]  o;
        logic [31:0] b;
        o = 3'($urandom_range(0, 7));
        b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        return {o, 1'($urandom_range(0, 1)), 32'($urandom), b};
    endfunction

    // Expected result of one instruction from the opcode table.
    function automatic void ref_eval(input logic [67:0] iw, output logic [31:0] d, output logic e);
        logic [31:0] a;
        logic [31:0] b;
        int unsigned opc;
        a = iw[63:32];
        b = iw[31:0];
        opc = iw[67:65];
        e = 1'b0;
        d = 32'd0;
        if (opc == 0) d = a + b;
        else if (opc == 1) d = a - b;
        else if (opc == 2) d = 32'(64'(a) * 64'(b));
        else if (opc == 3 && b != 0) d = a / b;
        else if (opc == 4) d = a << (b % 32);
        else if (opc == 5) d = a >> (b % 32);
        else e = 1'b1;
    endfunction

    function automatic void model_push(input logic [67:0] iw);
        exp_t x;
        ref_eval(iw, x.d, x.e);
        x.t = 4'(next_tag);
        next_tag = (next_tag + 1) % 16;
        exp_q.push_back(x);
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        next_tag = 0;
    endfunction

    // One clock: drive at the falling edge, sample, then pass the rising edge.
    task automatic cycle(input logic v, input logic [67:0] iw, input logic rr, output obs_t o);
        @(negedge clk);
        in_valid  = v;
        in_iw     = iw;
        res_ready = rr;
        #1;
        o.rdy = in_ready;
        o.acc = v && in_ready;
        o.rv  = res_valid;
        o.d   = res_data;
        o.t   = res_tag;
        o.e   = res_err;
        o.occ = occupancy;
        o.aiw = alu_iw;
        if (o.acc) model_push(iw);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_iw = 68'd0;
        res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        total++; if (res_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", res_data); end
        total++; if (res_tag !== 4'd0 || res_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%0d/%b exp=0/0", res_tag, res_err); end
        total++; if (occupancy !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_fifo occ=%0d rdy=%b exp=0/1", occupancy, in_ready); end
        total++; if (alu_iw !== 68'd0) begin bad++; $display("FAIL reset_aluiw got=%h exp=0", alu_iw); end
    endtask

    task automatic test_single_add();
        obs_t o;
        exp_t x;
        do_reset();
        cycle(1'b1, mk(0, 32'd5, 32'd7), 1'b1, o);
        total++; if (o.acc !== 1'b1) begin bad++; $display("FAIL add_accept got=%b exp=1", o.acc); end
        cycle(1'b0, 68'd0, 1'b1, o);
        total++; if (o.rv !== 1'b0) begin bad++; $display("FAIL add_early got=%b exp=0", o.rv); end
        total++; if (o.aiw !== mk(0, 32'd5, 32'd7)) begin bad++; $display("FAIL add_head got=%h exp=%h", o.aiw, mk(0, 32'd5, 32'd7)); end
        cycle(1'b0, 68'd0, 1'b1, o);
        x = exp_q.pop_front();
        total++;
        if (o.rv !== 1'b1 || o.d !== 32'd12 || o.d !== x.d || o.t !== 4'd0 || o.e !== 1'b0) begin
            bad++; $display("FAIL add_result v=%b d=%0d t=%0d e=%b exp v=1 d=12 t=0 e=0", o.rv, o.d, o.t, o.e);
        end
        cycle(1'b0, 68'd0, 1'b1, o);
        total++; if (o.rv !== 1'b0 || o.aiw !== 68'd0) begin bad++; $display("FAIL add_clear v=%b aiw=%h exp 0/0", o.rv, o.aiw); end
    endtask

    task automatic test_fill();
        obs_t o;
        exp_t x;
        int   nacc;
        nacc = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, mk($urandom_range(0, 5), $urandom, 32'($urandom_range(1, 31))), 1'b0, o);
            if (o.acc) nacc++;
        end
        total++; if (nacc !== 5) begin bad++; $display("FAIL fill_accepts got=%0d exp=5", nacc); end
        cycle(1'b0, 68'd0, 1'b0, o);
        total++; if (o.occ !== 3'd4 || o.rdy !== 1'b0 || o.rv !== 1'b1) begin
            bad++; $display("FAIL fill_full occ=%0d rdy=%b v=%b exp 4/0/1", o.occ, o.rdy, o.rv);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 68'd0, 1'b1, o);
            total++;
            if (o.rv !== 1'b1 || exp_q.size() == 0) begin
                bad++; $display("FAIL drain_valid idx=%0d got=%b exp=1", i, o.rv);
            end else begin
                x = exp_q.pop_front();
                if (o.d !== x.d || o.t !== 4'(i) || o.e !== x.e) begin
                    bad++; $display("FAIL drain_item idx=%0d got d=%h t=%0d e=%b exp d=%h t=%0d e=%b", i, o.d, o.t, o.e, x.d, i, x.e);
                end
            end
        end
        cycle(1'b0, 68'd0, 1'b1, o);
        total++; if (o.rv !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", o.rv); end
    endtask

    // Push two instructions with the consumer always ready and check both.
    task automatic test_pair(input string name, input logic [67:0] i0, input logic [31:0] d0, input logic e0,
                             input logic [67:0] i1, input logic [31:0] d1, input logic e1);
        obs_t o;
        exp_t x;
        int   got;
        got = 0;
        do_reset();
        cycle(1'b1, i0, 1'b1, o);
        cycle(1'b1, i1, 1'b1, o);
        for (int c = 0; c < 10 && got < 2; c++) begin
            cycle(1'b0, 68'd0, 1'b1, o);
            if (o.rv) begin
                x = exp_q.pop_front();
                total++;
                if (o.d !== (got == 0 ? d0 : d1) || o.e !== (got == 0 ? e0 : e1) || o.d !== x.d || o.e !== x.e || o.t !== 4'(got)) begin
                    bad++; $display("FAIL %s_%0d got d=%0d e=%b t=%0d exp d=%0d e=%b t=%0d", name, got, o.d, o.e, o.t,
                                    (got == 0 ? d0 : d1), (got == 0 ? e0 : e1), got);
                end
                got++;
            end
        end
        total++; if (got !== 2) begin bad++; $display("FAIL %s_count got=%0d exp=2", name, got); end
    endtask

    task automatic test_random_wrap();
        obs_t        o;
        exp_t        x;
        int          sent, got;
        logic        stall_prev;
        logic [31:0] pd;
        logic [3:0]  pt;
        logic        pe;
        logic        v, rr;
        sent = 0; got = 0; stall_prev = 1'b0; pd = 32'd0; pt = 4'd0; pe = 1'b0;
        do_reset();
        for (int c = 0; c < 600 && got < 18; c++) begin
            v  = (sent < 18) && ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            cycle(v, rand_iw(), rr, o);
            if (o.acc) sent++;
            if (stall_prev) begin
                total++;
                if (o.rv !== 1'b1 || o.d !== pd || o.t !== pt || o.e !== pe) begin
                    bad++; $display("FAIL stall_hold v=%b d=%h t=%0d e=%b exp v=1 d=%h t=%0d e=%b", o.rv, o.d, o.t, o.e, pd, pt, pe);
                end
            end
            if (o.rv && rr) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_extra got tag=%0d exp none", o.t);
                end else begin
                    x = exp_q.pop_front();
                    if (o.d !== x.d || o.t !== x.t || o.e !== x.e || o.t !== 4'(got % 16)) begin
                        bad++; $display("FAIL rand_item n=%0d got d=%h t=%0d e=%b exp d=%h t=%0d e=%b", got, o.d, o.t, o.e, x.d, got % 16, x.e);
                    end
                end
                got++;
            end
            stall_prev = o.rv && !rr;
            pd = o.d; pt = o.t; pe = o.e;
        end
        total++; if (got !== 18 || exp_q.size() != 0) begin bad++; $display("FAIL rand_count got=%0d exp=18 left=%0d", got, exp_q.size()); end
    endtask

    task automatic test_async_reset();
        obs_t o;
        exp_t x;
        int   got;
        got = 0;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(0, 32'(i), 32'd1), 1'b0, o);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (occupancy !== 3'd3 || res_valid !== 1'b1) begin bad++; $display("FAIL arst_setup occ=%0d v=%b exp 3/1", occupancy, res_valid); end
        #1 rst = 1'b1;
        #1;
        total++; if (res_valid !== 1'b0 || occupancy !== 3'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL arst_clear v=%b occ=%0d rdy=%b exp 0/0/1", res_valid, occupancy, in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        cycle(1'b1, mk(0, 32'd2, 32'd3), 1'b1, o);
        for (int c = 0; c < 6 && got < 1; c++) begin
            cycle(1'b0, 68'd0, 1'b1, o);
            if (o.rv) begin
                x = exp_q.pop_front();
                total++;
                if (o.t !== 4'd0 || o.d !== 32'd5 || o.d !== x.d || o.e !== 1'b0) begin
                    bad++; $display("FAIL arst_next got d=%0d t=%0d e=%b exp d=5 t=0 e=0", o.d, o.t, o.e);
                end
                got++;
            end
        end
        total++; if (got !== 1) begin bad++; $display("FAIL arst_next_count got=%0d exp=1", got); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_iw = 68'd0;
        res_ready = 1'b0;
        model_clear();
        test_reset();
        test_single_add();
        test_fill();
        test_pair("div", mk(3, 32'd100, 32'd0), 32'd0, 1'b1, mk(3, 32'd100, 32'd4), 32'd25, 1'b0);
        test_pair("illegal", mk(7, 32'd1, 32'd1), 32'd0, 1'b1, mk(1, 32'd9, 32'd3), 32'd6, 1'b0);
        test_random_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
